// File: rtl/branch_resolve_unit.sv
// Branch resolution at execute: in-order prediction FIFO, mispredict redirect/flush and predictor update strobes.
// Optional statistics counters are built when BRU_STATS_EN is defined; otherwise both count ports read 0.
module branch_resolve_unit #(
   parameter int PC           = 32,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             pred_valid_in,
   input  logic             pred_taken_in,
   input  logic [PC-1:0]    pred_target_in,
   output logic             pred_ready_out,
   input  logic             exe_valid_in,
   input  logic             exe_is_branch_in,
   input  logic [PC-1:0]    exe_pc_in,
   input  logic             exe_taken_in,
   input  logic [PC-1:0]    exe_target_in,
   output logic             redirect_valid_out,
   output logic [PC-1:0]    redirect_pc_out,
   output logic             flush_out,
   output logic             bpu_write_out,
   output logic [PC-1:0]    bpu_pc_out,
   output logic [PC-1:0]    bpu_new_pc_out,
   output logic             underflow_out,
   output logic [CNT_W-1:0] mispredict_count_out,
   output logic [CNT_W-1:0] branch_count_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t         state, state_next;
   logic [FW-1:0]  fcnt, fcnt_next;
   logic [AW:0]    wr_ptr, rd_ptr;
   logic           fifo_taken  [DEPTH];
   logic [PC-1:0]  fifo_target [DEPTH];
   logic           full, empty, push, pop, mispredict, bpu_upd;
   logic           head_taken;
   logic [PC-1:0]  head_target, correct_pc;

   assign empty          = (wr_ptr == rd_ptr);
   assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pred_ready_out = (state == RUN) && !full;
   assign push           = pred_valid_in && pred_ready_out;
   assign pop            = exe_valid_in && (state == RUN) && !empty;
   assign head_taken     = fifo_taken[rd_ptr[AW-1:0]];
   assign head_target    = fifo_target[rd_ptr[AW-1:0]];

   always_comb begin
      mispredict = 1'b0;
      if (pop) begin
         if (exe_is_branch_in)
            mispredict = (exe_taken_in != head_taken) ||
                         (exe_taken_in && head_taken && (exe_target_in != head_target));
         else
            mispredict = head_taken;
      end
      correct_pc = (exe_is_branch_in && exe_taken_in) ? exe_target_in : exe_pc_in + PC'(4);
      bpu_upd    = pop && ((exe_is_branch_in && exe_taken_in) || mispredict);
   end

   always_comb begin
      state_next = state;
      fcnt_next  = fcnt;
      case (state)
         RUN: begin
            if (mispredict) begin
               state_next = FLUSH;
               fcnt_next  = FW'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (fcnt == '0) state_next = RUN;
            else            fcnt_next  = fcnt - 1'b1;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_next;
         fcnt  <= fcnt_next;
      end
   end

   // Storage needs no reset: entries are only read when the pointers say they are valid.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_taken[wr_ptr[AW-1:0]]  <= pred_taken_in;
         fifo_target[wr_ptr[AW-1:0]] <= pred_target_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (mispredict) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         redirect_valid_out <= 1'b0;
         redirect_pc_out    <= '0;
         flush_out          <= 1'b0;
         bpu_write_out      <= 1'b0;
         bpu_pc_out         <= '0;
         bpu_new_pc_out     <= '0;
         underflow_out      <= 1'b0;
      end else begin
         redirect_valid_out <= mispredict;
         flush_out          <= (state_next == FLUSH);
         bpu_write_out      <= bpu_upd;
         if (mispredict) redirect_pc_out <= correct_pc;
         if (bpu_upd) begin
            bpu_pc_out     <= exe_pc_in;
            bpu_new_pc_out <= correct_pc;
         end
         if (exe_valid_in && (state == RUN) && empty) underflow_out <= 1'b1;
      end
   end

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] mis_cnt, br_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mis_cnt <= '0;
         br_cnt  <= '0;
      end else begin
         if (mispredict && (mis_cnt != '1))               mis_cnt <= mis_cnt + 1'b1;
         if (pop && exe_is_branch_in && (br_cnt != '1))   br_cnt  <= br_cnt + 1'b1;
      end
   end

   assign mispredict_count_out = mis_cnt;
   assign branch_count_out     = br_cnt;
`else
   assign mispredict_count_out = '0;
   assign branch_count_out     = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves branch predictions at execute, the return path of the branch prediction unit.
- Buffers each prediction issued at fetch in a small in-order FIFO. Pops one entry per instruction completing execute and compares the predicted direction and target against the actual outcome.
- On a mispredict, issues a redirect PC and a fixed-length pipeline flush. Also drives write/update strobes back into the predictor's history and target tables.

Parameters:
PC, 32, PC / target width in bits
DEPTH, 4, in-flight prediction FIFO entries (power of 2, >=2)
FLUSH_CYCLES, 2, cycles flush_out stays high after a mispredict (>=1)
CNT_W, 16, width of statistics counters

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
pred_valid_in  input  1  fetch pushes a prediction this cycle
pred_taken_in  input  1  predicted taken
pred_target_in  input  PC  predicted target (ignored if not taken)
pred_ready_out  output  1  FIFO can accept a push
exe_valid_in  input  1  instruction completes execute this cycle
exe_is_branch_in  input  1  instruction is a control-transfer
exe_pc_in  input  PC  PC of executing instruction
exe_taken_in  input  1  actual direction
exe_target_in  input  PC  actual target when taken
redirect_valid_out  output  1  one-cycle pulse: fetch must load redirect_pc_out
redirect_pc_out  output  PC  correct next PC
flush_out  output  1  kill fetch/decode stages
bpu_write_out  output  1  one-cycle pulse: update predictor tables
bpu_pc_out  output  PC  branch PC for the update
bpu_new_pc_out  output  PC  actual target for the update
underflow_out  output  1  sticky: exe_valid_in with FIFO empty
mispredict_count_out  output  CNT_W  saturating mispredict count
branch_count_out  output  CNT_W  saturating resolved-branch count

Behaviour:
- Async reset: FIFO empty, state RUN, all outputs 0, counters 0.
- pred_ready_out = (state==RUN) && !full. This output is combinational from registered state.
- Push occurs when pred_valid_in && pred_ready_out. A push while not ready is dropped.
- Pop occurs when exe_valid_in && state==RUN && !empty.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. Legal when full (ready is still 0, so no push occurs). Legal when empty (no bypass, so underflow_out sets).
- Pointers are log2(DEPTH)+1 bits, giving wrap-around full/empty detection.
- Mispredict rules, evaluated on pop using the head entry (p_taken, p_target):
  - branch and exe_taken_in != p_taken: mispredict.
  - branch and both taken and exe_target_in != p_target: mispredict.
  - non-branch and p_taken=1: mispredict.
- Correct next PC = exe_target_in if (branch && exe_taken_in), else exe_pc_in+4 (modulo 2^PC).
- All outputs are registered with 1-cycle latency from the exe_valid_in edge.
- On mispredict:
  - redirect_valid_out=1 and redirect_pc_out = correct PC.
  - flush_out=1.
  - The FIFO is cleared on the same edge.
  - state -> FLUSH with counter = FLUSH_CYCLES-1.
- bpu_write_out=1 with bpu_pc_out=exe_pc_in and bpu_new_pc_out = correct PC for every resolved branch that was taken or mispredicted. It pulses together with a redirect when both apply.
- FSM:
  - RUN: default. Transitions to FLUSH on mispredict.
  - FLUSH: flush_out=1, pushes and pops are blocked, exe_valid_in is ignored (no underflow). The counter decrements each cycle; at 0 the state returns to RUN and flush_out drops.
  - flush_out is high for exactly FLUSH_CYCLES cycles.
- underflow_out clears only on reset.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-flush aborts immediately to the reset values.

Optional Feature:
BRU_STATS_EN:
- Defined: mispredict_count_out increments on each mispredict pop. branch_count_out increments on each branch pop. Both saturate.
- Undefined: counter logic is not built and both ports are tied to 0. Ports remain present.

Test Plan:
1. Reset, push 4 predictions (taken=0): pred_ready_out=0 after the 4th. A 5th push is dropped. Pop 4 non-branches: no redirect, FIFO empty.
2. Push taken=1, target=0x100. Exe branch pc=0x40 taken, target 0x100 -> no redirect. bpu_write_out=1 with bpu_pc_out=0x40 and bpu_new_pc_out=0x100 on the next cycle.
3. Push taken=0. Exe branch pc=0x80 taken, target 0x200 -> redirect_valid_out pulse, redirect_pc_out=0x200, flush_out high 2 cycles, FIFO cleared, pred_ready_out=0 during flush. bpu_write_out=1.
4. Push taken=1, target=0x300. Exe branch pc=0xFFFFFFFC not taken -> redirect_pc_out=0x00000000 (wrap), flush 2 cycles.
5. exe_valid_in on empty FIFO -> underflow_out=1 and stays 1. exe_valid_in during FLUSH leaves state unchanged.
6. With BRU_STATS_EN: 3 branches, 1 mispredict -> branch_count_out=3, mispredict_count_out=1. Without the macro, both read 0.
